ok_wireout_poller: RTL and testbench
====================================

// Module: ok_wireout_poller
// PURPOSE
//  Host-side sequencer for the Wire Out protocol. Issues one wire-update pulse so every
//  Wire Out endpoint latches its ep_datain, then walks the target address across a
//  contiguous wire range and captures each endpoint's returned data word.
//  Captured words land in a local register file for the testbench / host model to read.
//  Sits in simulation beside the endpoint models and drives their shared okHE fields.
// PARAMETERS
//  FIRST_ADDR  8'h20  endpoint address of capture slot 0
//  NUM_WIRES   32     number of consecutive addresses swept, legal range 1..64
//  SETTLE      1      extra hold cycles per address before sampling, legal range 0..15
// PORTS
//  ti_clk         in   1   host interface clock; all logic on rising edge
//  ti_reset       in   1   asynchronous, active-high reset
//  start          in   1   request a sweep; sampled only in IDLE
//  busy           out  1   high in every state except IDLE
//  done           out  1   one-cycle pulse when a sweep completes
//  ti_wireupdate  out  1   one-cycle latch pulse to all Wire Out endpoints
//  ti_addr        out  8   endpoint address currently selected
//  eh_data        in   32  OR of all endpoint okEH data fields (0 when no endpoint matches)
//  rd_idx         in   6   capture slot to read
//  rd_data        out  32  combinational mem[rd_idx]; 0 when rd_idx >= NUM_WIRES
//  sweep_count    out  16  completed sweeps since reset; wraps FFFF -> 0000
// BEHAVIOUR
//  Reset (asynchronous, active-high)
//   - state = IDLE; busy, done, ti_wireupdate = 0; ti_addr = 8'h00; sweep_count = 0.
//   - All capture slots = 0. Holds for a mid-sweep reset too; no partial completion.
//  FSM states: IDLE, UPDATE, ADDR, DONE
//   - IDLE: ti_addr = 8'h00; start=1 -> UPDATE.
//   - UPDATE: ti_wireupdate = 1 for exactly this cycle; idx = 0, settle counter = 0 -> ADDR.
//   - ADDR: ti_addr = (FIRST_ADDR + idx) mod 256.
//     - While cnt < SETTLE: cnt++.
//     - When cnt == SETTLE: mem[idx] <= eh_data, cnt = 0.
//     - Then if idx == NUM_WIRES-1 -> DONE; otherwise idx++ and stay in ADDR.
//   - DONE: done = 1, sweep_count++, ti_addr = 8'h00 -> IDLE.
//  Timing
//   - start is seen in the IDLE cycle; UPDATE follows on the next edge.
//   - Each wire takes SETTLE+1 cycles.
//   - Start-to-done pulse = 2 + NUM_WIRES*(SETTLE+1) cycles.
//  start handling: ignored in UPDATE, ADDR and DONE; no queuing. If start stays high,
//   the next sweep begins on the cycle after DONE, with exactly one ti_wireupdate per sweep.
//  Captured data is the value latched by the endpoints at the UPDATE pulse. Later
//   ep_datain changes during the sweep are not visible.
//  Slots keep their last value between sweeps; each slot is overwritten when its index
//   is sampled.
//  ti_addr is the only address source; no slot is sampled with a stale address.
// TESTING
//  1 Reset: assert ti_reset, then release -> busy=0, done=0, ti_wireupdate=0, ti_addr=00,
//    sweep_count=0, rd_data=0 for all rd_idx 0..63.
//  2 Basic sweep, defaults: endpoints at 0x20 (DEADBEEF) and 0x25 (12345678), start pulse
//    -> done 66 cycles later; slot0=DEADBEEF, slot5=12345678, other slots 0, sweep_count=1.
//  3 Latch check: change 0x25 datain to 0 one cycle after ti_wireupdate -> slot5 still 12345678.
//  4 start held high for 3 sweeps -> 3 wireupdate pulses and 3 done pulses, each 67 cycles
//    apart; sweep_count=3.
//  5 Reset mid-sweep at idx=10 -> next edge busy=0, all slots 0; next start gives a full
//    66-cycle sweep.
//  6 SETTLE=0, NUM_WIRES=1, FIRST_ADDR=8'hFF -> ti_addr=FF for 1 cycle, done 3 cycles
//    after start; rd_idx=1 -> rd_data=0.

Source files
------------

// File: rtl/ok_wireout_poller_if.sv
// Wire Out poller bundle: sweep control, okHE/okEH fields and capture read port.
//   master : the poller (drives busy/done/ti_wireupdate/ti_addr/rd_data/sweep_count)
//   slave  : host model + endpoints (drives start/eh_data/rd_idx)
interface ok_wireout_poller_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        ti_wireupdate;
  logic [7:0]  ti_addr;
  logic [31:0] eh_data;
  logic [5:0]  rd_idx;
  logic [31:0] rd_data;
  logic [15:0] sweep_count;

  modport master (
    input  start, eh_data, rd_idx,
    output busy, done, ti_wireupdate, ti_addr, rd_data, sweep_count
  );

  modport slave (
    output start, eh_data, rd_idx,
    input  busy, done, ti_wireupdate, ti_addr, rd_data, sweep_count
  );
endinterface

// File: rtl/ok_wireout_poller.sv
// Host-side Wire Out sequencer. One ti_wireupdate pulse makes every endpoint
// latch its input, then ti_addr walks FIRST_ADDR..FIRST_ADDR+NUM_WIRES-1 and
// each returned eh_data word is captured into a slot of a local register file.
// Ports:
//   ti_clk   : clock, rising edge
//   ti_reset : asynchronous active-high reset
//   bus      : ok_wireout_poller_if.master (start/busy/done, okHE/okEH fields,
//              capture read port rd_idx/rd_data, sweep_count)
module ok_wireout_poller #(
  parameter logic [7:0] FIRST_ADDR = 8'h20,
  parameter int         NUM_WIRES  = 32,
  parameter int         SETTLE     = 1
) (
  input logic             ti_clk,
  input logic             ti_reset,
  ok_wireout_poller_if.master bus
);

  if (NUM_WIRES < 1 || NUM_WIRES > 64) begin : g_bad_num_wires
    $error("NUM_WIRES must be 1..64");
  end
  if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
    $error("SETTLE must be 0..15");
  end

  localparam logic [5:0] LAST_IDX = 6'(NUM_WIRES - 1);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [6:0] NW_C     = 7'(NUM_WIRES);

  typedef enum logic [1:0] {IDLE, UPDATE, ADDR, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sweep_q;
  logic [31:0] mem_q [64];
  logic        sample;

  // State register
  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = UPDATE;
      UPDATE: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ADDR;
      end
      ADDR: begin
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs (Moore); ti_addr only leaves 00 while an address is being held,
  // so no slot can be sampled against a stale address.
  always_comb begin
    bus.busy          = (state_q != IDLE);
    bus.done          = (state_q == DONE);
    bus.ti_wireupdate = (state_q == UPDATE);
    bus.ti_addr       = (state_q == ADDR) ? FIRST_ADDR + {2'b00, idx_q} : 8'h00;
    sample            = (state_q == ADDR) && (cnt_q == SETTLE_C);
  end

  // Completed-sweep counter, wraps naturally at 16 bits
  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset)              sweep_q <= '0;
    else if (state_q == DONE)  sweep_q <= sweep_q + 16'd1;
  end

  // Capture slots: cleared by reset, otherwise each keeps its value until
  // its own index is sampled again.
  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (sample) begin
      mem_q[idx_q] <= bus.eh_data;
    end
  end

  assign bus.sweep_count = sweep_q;
  assign bus.rd_data     = ({1'b0, bus.rd_idx} < NW_C) ? mem_q[bus.rd_idx] : 32'h0;

endmodule

// File: tb/tb_ok_wireout_poller.sv
module tb_ok_wireout_poller;
  localparam int FA = 32'h20;
  localparam int NW = 32;
  localparam int ST = 1;
  localparam int L  = NW * (ST + 1);

  logic ti_clk   = 1'b0;
  logic ti_reset = 1'b0;
  always #5 ti_clk = ~ti_clk;

  ok_wireout_poller_if ifa ();
  ok_wireout_poller_if ifb ();

  ok_wireout_poller #(.FIRST_ADDR(8'h20), .NUM_WIRES(32), .SETTLE(1)) dut_a (
    .ti_clk(ti_clk), .ti_reset(ti_reset), .bus(ifa.master));
  ok_wireout_poller #(.FIRST_ADDR(8'hFF), .NUM_WIRES(1), .SETTLE(0)) dut_b (
    .ti_clk(ti_clk), .ti_reset(ti_reset), .bus(ifb.master));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge ti_clk);
    #1;
  endtask

  // Endpoint models: ep_din is what each endpoint presents, ep_lat what it
  // latched on the last wire-update pulse.
  logic [31:0] ep_din [256];
  logic [31:0] ep_lat [256];
  initial begin
    for (int i = 0; i < 256; i++) ep_lat[i] = '0;
    forever begin
      @(posedge ti_clk);
      if (ifa.ti_wireupdate === 1'b1)
        for (int i = 0; i < 256; i++) ep_lat[i] = ep_din[i];
    end
  end
  assign ifa.eh_data = ep_lat[ifa.ti_addr];
  assign ifb.eh_data = (ifb.ti_addr == 8'hFF) ? 32'hA5A50F0F : 32'h0;

  // Reference model: mk = cycles since the update pulse (-1 when idle).
  int          mk = -1;
  logic [15:0] mcnt;
  logic [31:0] mmem  [64];
  logic [31:0] m_lat [256];
  initial begin
    for (int i = 0; i < 256; i++) m_lat[i] = '0;
    forever begin
      @(posedge ti_clk or posedge ti_reset);
      if (ti_reset) begin
        mk = -1;
        mcnt = '0;
        for (int i = 0; i < 64; i++) mmem[i] = '0;
      end else if (mk < 0) begin
        if (ifa.start) mk = 0;
      end else if (mk == 0) begin
        for (int i = 0; i < 256; i++) m_lat[i] = ep_din[i];
        mk = 1;
      end else if (mk <= L) begin
        if ((mk - 1) % (ST + 1) == ST)
          mmem[(mk - 1) / (ST + 1)] = m_lat[(FA + (mk - 1) / (ST + 1)) % 256];
        mk++;
      end else begin
        mcnt = mcnt + 16'd1;
        mk = -1;
      end
    end
  end

  // Per-cycle compare of DUT A against the model
  initial begin
    logic [7:0]  ea;
    logic [31:0] er;
    forever begin
      @(negedge ti_clk);
      if (chk_en) begin
        ea = (mk >= 1 && mk <= L) ? 8'((FA + (mk - 1) / (ST + 1)) % 256) : 8'h00;
        er = (int'(ifa.rd_idx) < NW) ? mmem[ifa.rd_idx] : 32'h0;
        chk("m.busy", {31'b0, ifa.busy}, {31'b0, mk >= 0});
        chk("m.done", {31'b0, ifa.done}, {31'b0, mk == L + 1});
        chk("m.wu", {31'b0, ifa.ti_wireupdate}, {31'b0, mk == 0});
        chk("m.addr", {24'b0, ifa.ti_addr}, {24'b0, ea});
        chk("m.count", {16'b0, ifa.sweep_count}, {16'b0, mcnt});
        chk("m.rd_data", ifa.rd_data, er);
      end
    end
  end

  initial begin
    int cyc, nwu, nd, last, n;
    ifa.start = 0; ifa.rd_idx = 0;
    ifb.start = 0; ifb.rd_idx = 0;
    for (int i = 0; i < 256; i++) ep_din[i] = '0;

    // 1: reset
    #2 ti_reset = 1'b1;
    repeat (2) tick();
    chk("rst.busy", {31'b0, ifa.busy}, 32'd0);
    chk("rst.done", {31'b0, ifa.done}, 32'd0);
    ti_reset = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst.wu", {31'b0, ifa.ti_wireupdate}, 32'd0);
    chk("rst.addr", {24'b0, ifa.ti_addr}, 32'h00);
    chk("rst.count", {16'b0, ifa.sweep_count}, 32'd0);
    for (int r = 0; r < 64; r++) begin
      ifa.rd_idx = 6'(r);
      tick();
      chk("rst.slot", ifa.rd_data, 32'h0);
    end

    // 2+3: basic sweep with post-latch datain change
    ep_din[8'h20] = 32'hDEADBEEF;
    ep_din[8'h25] = 32'h12345678;
    ifa.start = 1'b1;
    cyc = 0;
    tick(); cyc++;
    ifa.start = 1'b0;
    chk("t2.wu", {31'b0, ifa.ti_wireupdate}, 32'd1);
    tick(); cyc++;
    ep_din[8'h25] = 32'h0;
    while (ifa.done !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    chk("t2.latency", cyc, 32'd66);
    ifa.rd_idx = 0;
    tick();
    chk("t2.count", {16'b0, ifa.sweep_count}, 32'd1);
    chk("t2.slot0", ifa.rd_data, 32'hDEADBEEF);
    ifa.rd_idx = 5;
    tick();
    chk("t3.slot5", ifa.rd_data, 32'h12345678);
    ifa.rd_idx = 1;
    tick();
    chk("t2.slot1", ifa.rd_data, 32'h0);

    // 4: start held for three sweeps
    ti_reset = 1'b1; tick(); ti_reset = 1'b0; tick();
    ifa.start = 1'b1;
    cyc = 0; nwu = 0; nd = 0; last = -1;
    while (nd < 3 && cyc < 400) begin
      tick(); cyc++;
      if (ifa.ti_wireupdate === 1'b1) nwu++;
      if (ifa.done === 1'b1) begin
        nd++;
        if (last < 0) chk("t4.first", cyc, 32'd66);
        else          chk("t4.spacing", cyc - last, 32'd67);
        last = cyc;
        if (nd == 3) ifa.start = 1'b0;
      end
    end
    chk("t4.dones", nd, 32'd3);
    chk("t4.wus", nwu, 32'd3);
    tick();
    chk("t4.count", {16'b0, ifa.sweep_count}, 32'd3);
    chk("t4.idle", {31'b0, ifa.busy}, 32'd0);

    // 5: reset at idx 10
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    n = 0;
    while (ifa.ti_addr !== 8'h2A && n < 100) begin tick(); n++; end
    chk("t5.reach_idx10", {24'b0, ifa.ti_addr}, 32'h2A);
    ti_reset = 1'b1;
    #1;
    chk("t5.async_busy", {31'b0, ifa.busy}, 32'd0);
    tick();
    ti_reset = 1'b0;
    for (int r = 0; r < 64; r++) begin
      ifa.rd_idx = 6'(r);
      tick();
      chk("t5.slot", ifa.rd_data, 32'h0);
    end
    ifa.start = 1'b1;
    cyc = 0;
    tick(); cyc++;
    ifa.start = 1'b0;
    while (ifa.done !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    chk("t5.latency", cyc, 32'd66);
    tick();

    // 6: single wire, no settle, address FF
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    chk("t6.wu", {31'b0, ifb.ti_wireupdate}, 32'd1);
    chk("t6.addr_upd", {24'b0, ifb.ti_addr}, 32'h00);
    tick();
    chk("t6.addr_ff", {24'b0, ifb.ti_addr}, 32'hFF);
    tick();
    chk("t6.done", {31'b0, ifb.done}, 32'd1);
    chk("t6.addr_done", {24'b0, ifb.ti_addr}, 32'h00);
    ifb.rd_idx = 0;
    tick();
    chk("t6.slot0", ifb.rd_data, 32'hA5A50F0F);
    chk("t6.count", {16'b0, ifb.sweep_count}, 32'd1);
    chk("t6.idle", {31'b0, ifb.busy}, 32'd0);
    ifb.rd_idx = 1;
    tick();
    chk("t6.slot1", ifb.rd_data, 32'h0);

    // Random traffic against the model
    repeat (4000) begin
      if ($urandom % 8 == 0) ifa.start = 1'($urandom % 2);
      ifa.rd_idx = 6'($urandom % 64);
      if ($urandom % 3 == 0) ep_din[$urandom_range(24, 72)] = $urandom;
      ti_reset = ($urandom % 700 == 0);
      tick();
    end
    ti_reset = 1'b0;
    ifa.start = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
